pe_group_mac_n: RTL and testbench

Parametrised successor to the 5-tap PE group. It computes a K-tap signed dot product of weights and ifmaps in a 3-stage pipeline: multiply, adder tree, then accumulate/shift/saturate. It accumulates across a variable number of input beats, delimited by in_last, so channel counts larger than K reduce in one PE group. It sits between the ifmap/weight buffers and the writeback unit, and gives writeback a valid strobe and a drain-done pulse.

---
 rtl/pe_group_mac_n.sv | 152 +++++++++++++++
 tb/tb_pe_group_mac_n.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_group_mac_n.sv
// K-tap signed dot-product PE group: multiply, adder tree, then accumulate/shift/saturate over in_last-delimited beats.
// Optional build macro PE_RELU_EN clamps negative results to zero after saturation.
module pe_group_mac_n #(
  parameter int K         = 5,
  parameter int DW        = 8,
  parameter int OW        = 11,
  parameter int ACC_EXTRA = 4,
  parameter int SHW       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [K*DW-1:0]   weights,
  input  logic [K*DW-1:0]   ifmaps,
  input  logic [SHW-1:0]    cfg_shift,
  input  logic              flush,
  output logic              out_valid,
  output logic [OW-1:0]     out_data,
  output logic              busy,
  output logic              drain_done
);
  localparam int PW = 2 * DW;
  localparam int SW = PW + $clog2(K);
  localparam int AW = SW + ACC_EXTRA;

  localparam logic signed [AW-1:0] OUT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OUT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Stage 1: per-tap products
  logic signed [PW-1:0] prod_d [K];
  logic signed [PW-1:0] prod_q [K];
  logic                 v1_q, l1_q;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_mul
      logic signed [DW-1:0] w_tap;
      logic signed [DW-1:0] f_tap;
      assign w_tap      = weights[gi*DW +: DW];
      assign f_tap      = ifmaps[gi*DW +: DW];
      assign prod_d[gi] = w_tap * f_tap;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) prod_q[i] <= '0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
    end else begin
      for (int i = 0; i < K; i++) prod_q[i] <= prod_d[i];
      v1_q <= in_valid & ~flush;
      l1_q <= in_valid & in_last & ~flush;
    end
  end

  // Stage 2: full-precision sum of sign-extended products
  logic signed [SW-1:0] sum_d, sum_q;
  logic                 v2_q, l2_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < K; i++)
      sum_d = sum_d + {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
      v2_q  <= 1'b0;
      l2_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      v2_q  <= v1_q & ~flush;
      l2_q  <= l1_q & ~flush;
    end
  end

  // Stage 3: accumulate, then shift/saturate on the group's last beat
  logic signed [AW-1:0] acc_q, acc_next, shifted;
  logic        [OW-1:0] sat_d, res_d;
  logic        [OW-1:0] out_data_q;
  logic                 out_valid_q;
  logic                 open_q;

  always_comb begin
    acc_next = acc_q + {{(AW-SW){sum_q[SW-1]}}, sum_q};
    shifted  = acc_next >>> cfg_shift;
    if (shifted > OUT_MAX)
      sat_d = OUT_MAX[OW-1:0];
    else if (shifted < OUT_MIN)
      sat_d = OUT_MIN[OW-1:0];
    else
      sat_d = shifted[OW-1:0];
`ifdef PE_RELU_EN
    res_d = sat_d[OW-1] ? '0 : sat_d;
`else
    res_d = sat_d;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (v2_q) begin
      if (l2_q) begin
        out_data_q  <= res_d;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
      end else begin
        acc_q       <= acc_next;
        out_valid_q <= 1'b0;
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  // Open-group flag keeps busy high even when a partial sum happens to be zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      open_q <= 1'b0;
    else if (flush)
      open_q <= 1'b0;
    else if (in_valid)
      open_q <= ~in_last;
  end

  logic busy_q, drain_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      busy_q       <= busy;
      drain_done_q <= busy_q & ~busy;
    end
  end

  assign busy       = v1_q | v2_q | (acc_q != '0) | open_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign drain_done = drain_done_q;

endmodule

// File: tb/tb_pe_group_mac_n.sv
// Testbench for pe_group_mac_n: directed test-plan steps plus randomized groups against a beat-queue reference model.
module tb_pe_group_mac_n;
  localparam int K         = 5;
  localparam int DW        = 8;
  localparam int OW        = 11;
  localparam int ACC_EXTRA = 4;
  localparam int SHW       = 4;
  localparam int AW        = 2*DW + $clog2(K) + ACC_EXTRA;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            flush = 1'b0;
  logic [K*DW-1:0] weights = '0;
  logic [K*DW-1:0] ifmaps = '0;
  logic [SHW-1:0]  cfg_shift = '0;
  logic            out_valid;
  logic [OW-1:0]   out_data;
  logic            busy;
  logic            drain_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_group_mac_n #(.K(K), .DW(DW), .OW(OW), .ACC_EXTRA(ACC_EXTRA), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .weights(weights), .ifmaps(ifmaps), .cfg_shift(cfg_shift), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .drain_done(drain_done)
  );

  // Reference model: beats wait in a queue tagged with their sampling edge
  typedef struct { int cyc; longint sum; bit last; } beat_t;
  beat_t  pend[$];
  int     cyc = 0;
  longint m_acc = 0;
  bit     m_open = 0;
  bit     m_ov = 0;
  longint m_out = 0;
  bit     m_busy = 0, hist1 = 0, hist2 = 0, m_dd = 0;

  int     n_out = 0;
  longint last_out = 0;
  longint outs[$];
  int     out_cyc[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint a);
    longint m;
    m = a & ((longint'(1) <<< AW) - 1);
    if (m[AW-1]) m = m - (longint'(1) <<< AW);
    return m;
  endfunction

  function automatic longint post(input longint a);
    longint s;
    s = a >>> cfg_shift;
    if (s > (longint'(1) <<< (OW-1)) - 1) s = (longint'(1) <<< (OW-1)) - 1;
    else if (s < -(longint'(1) <<< (OW-1))) s = -(longint'(1) <<< (OW-1));
`ifdef PE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic longint beat_sum();
    longint s, a, b;
    s = 0;
    for (int i = 0; i < K; i++) begin
      a = longint'($signed(weights[i*DW +: DW]));
      b = longint'($signed(ifmaps[i*DW +: DW]));
      s += a * b;
    end
    return s;
  endfunction

  task automatic model_edge();
    beat_t b;
    cyc++;
    m_dd = hist2 && !hist1;
    if (flush) begin
      pend.delete();
      m_acc  = 0;
      m_open = 0;
      m_ov   = 0;
    end else begin
      m_ov = 0;
      if (pend.size() > 0 && pend[0].cyc == cyc - 2) begin
        b = pend.pop_front();
        m_acc = wrap_acc(m_acc + b.sum);
        if (b.last) begin
          m_out = post(m_acc);
          m_ov  = 1;
          m_acc = 0;
        end
      end
      if (in_valid) begin
        pend.push_back('{cyc, beat_sum(), in_last});
        m_open = !in_last;
      end
    end
    m_busy = (pend.size() > 0) || (m_acc != 0) || m_open;
    hist2 = hist1;
    hist1 = m_busy;
  endtask

  task automatic model_reset();
    pend.delete();
    m_acc = 0; m_open = 0; m_ov = 0; m_out = 0;
    m_busy = 0; hist1 = 0; hist2 = 0; m_dd = 0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".out_valid"}, out_valid, m_ov);
    chk({ctx, ".out_data"}, $signed(out_data), m_out);
    chk({ctx, ".busy"}, busy, m_busy);
    chk({ctx, ".drain_done"}, drain_done, m_dd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("cyc");
    if (out_valid === 1'b1) begin
      n_out++;
      last_out = longint'($signed(out_data));
      outs.push_back(last_out);
      out_cyc.push_back(cyc);
      $display("out #%0d cyc=%0d data=%0d shift=%0d", n_out, cyc, last_out, cfg_shift);
    end
  endtask

  task automatic set_taps(input int w, input int f);
    logic [31:0] wv, fv;
    wv = w;
    fv = f;
    for (int i = 0; i < K; i++) begin
      weights[i*DW +: DW] = wv[DW-1:0];
      ifmaps[i*DW +: DW]  = fv[DW-1:0];
    end
  endtask

  task automatic beat(input bit last, input int w, input int f);
    in_valid = 1'b1;
    in_last  = last;
    set_taps(w, f);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic single_group(input string tag, input int w, input int f, input int sh, input longint expv);
    int n0;
    cfg_shift = SHW'(sh);
    n0 = n_out;
    beat(1'b1, w, f);
    idle(4);
    chk({tag, ".count"}, n_out - n0, 1);
    chk({tag, ".value"}, last_out, expv);
  endtask

  initial begin
    int n0, glen, lim;
    #1;
    check_outputs("reset");
    #1 rst = 1'b1;

    // Single beat 3*10*5 = 150; model checks latency and drain_done timing per cycle
    single_group("basic150", 3, 10, 0, 150);
    single_group("max_sh7", 127, 127, 7, 630);
    single_group("max_sat", 127, 127, 0, 1023);
`ifdef PE_RELU_EN
    single_group("neg_sat", 127, -128, 0, 0);
`else
    single_group("neg_sat", 127, -128, 0, -1024);
`endif

    // Three beats with two-cycle bubbles; busy must stay high across the gaps
    cfg_shift = '0;
    n0 = n_out;
    beat(1'b0, 3, 10);
    idle(2);
    chk("gap.busy", busy, 1);
    beat(1'b0, 3, 10);
    in_last = 1'b1;
    idle(2);
    chk("gap.busy2", busy, 1);
    beat(1'b1, 3, 10);
    idle(4);
    chk("multi.count", n_out - n0, 1);
    chk("multi.value", last_out, 450);

    // Back-to-back single-beat groups
    outs.delete();
    out_cyc.delete();
    beat(1'b1, 3, 10);
    beat(1'b1, -1, 6);
    idle(4);
    chk("b2b.count", outs.size(), 2);
    if (outs.size() == 2) begin
      chk("b2b.first", outs[0], 150);
`ifdef PE_RELU_EN
      chk("b2b.second", outs[1], 0);
`else
      chk("b2b.second", outs[1], -30);
`endif
      chk("b2b.adjacent", out_cyc[1] - out_cyc[0], 1);
    end

    // Flush together with the closing beat drops the group entirely
    n0 = n_out;
    beat(1'b0, 3, 10);
    flush = 1'b1;
    beat(1'b1, 3, 10);
    flush = 1'b0;
    idle(5);
    chk("flush.no_out", n_out - n0, 0);
    single_group("after_flush", 3, 10, 0, 150);

    // Asynchronous reset between edges in the middle of a group
    beat(1'b0, 3, 10);
    beat(1'b0, 3, 10);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("held_rst");
    rst = 1'b1;
    single_group("after_rst", 3, 10, 0, 150);

    // Randomized groups: random taps, shift, length, bubbles and occasional flush
    for (int g = 0; g < 40; g++) begin
      lim = 0;
      while (m_busy && lim < 10) begin
        idle(1);
        lim++;
      end
      chk("rand.idle_reached", m_busy, 0);
      cfg_shift = SHW'($urandom_range(0, 15));
      glen = $urandom_range(1, 6);
      for (int b = 0; b < glen; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));
          tick();
        end
        for (int i = 0; i < K; i++) begin
          weights[i*DW +: DW] = DW'($urandom());
          ifmaps[i*DW +: DW]  = DW'($urandom());
        end
        flush    = ($urandom_range(0, 19) == 0);
        in_valid = 1'b1;
        in_last  = (b == glen - 1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
